// File: rtl/fft_butterfly_stage.sv
// Gao-Mateer butterfly stage of the additive FFT: reads the reduction stage's
// A/B coefficient rows, computes e0 = A ^ B*w and e1 = e0 ^ B per lane, streams pairs out.

module gf_mul #(
  parameter int unsigned   gf   = 13,
  parameter logic [gf-1:0] poly = 13'h001B
) (
  input  logic [gf-1:0] a,
  input  logic [gf-1:0] b,
  output logic [gf-1:0] p
);

  logic [gf-1:0] acc;
  logic [gf-1:0] sh;

  // Shift-and-add multiply; reduction is folded into each doubling of a.
  always_comb begin
    acc = '0;
    sh  = a;
    for (int unsigned i = 0; i < gf; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[gf-2:0], 1'b0} ^ (sh[gf-1] ? poly : '0);
    end
    p = acc;
  end

endmodule

module fft_butterfly_stage #(
  parameter int unsigned   gf        = 13,
  parameter int unsigned   mem_width = 4,
  parameter int unsigned   num_power = 6,
  parameter logic [gf-1:0] poly      = 13'h001B
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [mem_width*gf-1:0]   twiddle,
  input  logic                      red_done,
  output logic                      rd_en,
  output logic [num_power-1:0]      rd_addr,
  input  logic [mem_width*gf-1:0]   mem_A_din,
  input  logic [mem_width*gf-1:0]   mem_B_din,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [mem_width*gf-1:0]   out_e0,
  output logic [mem_width*gf-1:0]   out_e1,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned W = mem_width * gf;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STREAM, S_DONE} state_t;

  state_t               state;
  logic [W-1:0]         tw;
  logic [W-1:0]         e0_new;
  logic [W-1:0]         e1_new;
  logic [W-1:0]         slot1_e0;
  logic [W-1:0]         slot1_e1;
  logic                 inflight;
  logic                 all_issued;
  logic [1:0]           fifo_count;
  logic [num_power-1:0] acc_count;
  logic [2:0]           occ;
  logic                 push;
  logic                 pop;
  logic                 issue;

  for (genvar l = 0; l < mem_width; l++) begin : g_lane
    logic [gf-1:0] prod;

    gf_mul #(.gf(gf), .poly(poly)) u_mul (
      .a(mem_B_din[l*gf +: gf]),
      .b(tw[l*gf +: gf]),
      .p(prod)
    );

    assign e0_new[l*gf +: gf] = mem_A_din[l*gf +: gf] ^ prod;
    assign e1_new[l*gf +: gf] = e0_new[l*gf +: gf] ^ mem_B_din[l*gf +: gf];
  end

  assign push      = inflight;
  assign out_valid = (fifo_count != 2'd0);
  assign pop       = out_valid & out_ready;
  assign occ       = {1'b0, fifo_count} + {2'b00, inflight};

  // A pop in this cycle frees the slot the new read will land in, which is what
  // sustains one row per cycle with only two entries of buffering.
  assign issue = (state == S_STREAM) && !all_issued &&
                 ((occ < 3'd2) || (occ == 3'd2 && pop && fifo_count == 2'd1));

  assign rd_en = issue;
  assign busy  = (state != S_IDLE);
  assign done  = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      tw         <= '0;
      rd_addr    <= '0;
      all_issued <= 1'b0;
      inflight   <= 1'b0;
      fifo_count <= '0;
      out_e0     <= '0;
      out_e1     <= '0;
      slot1_e0   <= '0;
      slot1_e1   <= '0;
      acc_count  <= '0;
    end else begin
      inflight <= issue;

      if (issue) begin
        if (&rd_addr) all_issued <= 1'b1;
        else          rd_addr    <= rd_addr + num_power'(1);
      end

      case ({push, pop})
        2'b10: begin
          if (fifo_count == 2'd0) begin
            out_e0 <= e0_new;
            out_e1 <= e1_new;
          end else begin
            slot1_e0 <= e0_new;
            slot1_e1 <= e1_new;
          end
          fifo_count <= fifo_count + 2'd1;
        end
        2'b01: begin
          out_e0     <= slot1_e0;
          out_e1     <= slot1_e1;
          fifo_count <= fifo_count - 2'd1;
        end
        2'b11: begin
          if (fifo_count == 2'd1) begin
            out_e0 <= e0_new;
            out_e1 <= e1_new;
          end else begin
            out_e0   <= slot1_e0;
            out_e1   <= slot1_e1;
            slot1_e0 <= e0_new;
            slot1_e1 <= e1_new;
          end
        end
        default: ;
      endcase

      case (state)
        S_IDLE: begin
          if (start) begin
            tw         <= twiddle;
            rd_addr    <= '0;
            all_issued <= 1'b0;
            acc_count  <= '0;
            state      <= red_done ? S_STREAM : S_WAIT;
          end
        end
        S_WAIT: begin
          if (red_done) state <= S_STREAM;
        end
        S_STREAM: begin
          if (pop) begin
            acc_count <= acc_count + num_power'(1);
            if (&acc_count) state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_butterfly_stage.sv
// Scoreboard bench for fft_butterfly_stage: a 4-row instance for directed
// scenarios and a 64-row instance for randomized backpressure runs.

module tb_fft_butterfly_stage;

  localparam int GF    = 13;
  localparam int MW    = 2;
  localparam int W     = MW * GF;
  localparam int NP    = 2;
  localparam int ROWS  = 4;
  localparam int NPL   = 6;
  localparam int ROWSL = 64;
  localparam logic [GF-1:0] POLY = 13'h001B;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  logic          start = 1'b0, red_done = 1'b0, out_ready = 1'b0;
  logic [W-1:0]  twiddle = '0, a_din = '0, b_din = '0, out_e0, out_e1;
  logic          rd_en, out_valid, busy, done;
  logic [NP-1:0] rd_addr;
  logic [GF-1:0] b_lane = '0;

  logic           l_start = 1'b0, l_red_done = 1'b0, l_out_ready = 1'b0;
  logic [W-1:0]   l_twiddle = '0, l_a = '0, l_b = '0, l_e0, l_e1;
  logic           l_rd_en, l_out_valid, l_busy, l_done;
  logic [NPL-1:0] l_rd_addr;
  logic [GF-1:0]  l_b_lane = '0;

  int vectors = 0;
  int miscompares = 0;
  logic [2*W-1:0] sb[$];

  fft_butterfly_stage #(.gf(GF), .mem_width(MW), .num_power(NP), .poly(POLY)) dut (
    .clk(clk), .rst(rst), .start(start), .twiddle(twiddle), .red_done(red_done),
    .rd_en(rd_en), .rd_addr(rd_addr), .mem_A_din(a_din), .mem_B_din(b_din),
    .out_valid(out_valid), .out_ready(out_ready), .out_e0(out_e0), .out_e1(out_e1),
    .busy(busy), .done(done)
  );

  fft_butterfly_stage #(.gf(GF), .mem_width(MW), .num_power(NPL), .poly(POLY)) dut_l (
    .clk(clk), .rst(rst), .start(l_start), .twiddle(l_twiddle), .red_done(l_red_done),
    .rd_en(l_rd_en), .rd_addr(l_rd_addr), .mem_A_din(l_a), .mem_B_din(l_b),
    .out_valid(l_out_valid), .out_ready(l_out_ready), .out_e0(l_e0), .out_e1(l_e1),
    .busy(l_busy), .done(l_done)
  );

  // Reduction memory models: row r holds A lanes {r+1, r+5}, B lanes all b_lane.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      a_din <= {GF'(rd_addr) + 13'd5, GF'(rd_addr) + 13'd1};
      b_din <= {b_lane, b_lane};
    end
    if (l_rd_en) begin
      l_a <= {GF'(l_rd_addr) + 13'd5, GF'(l_rd_addr) + 13'd1};
      l_b <= {l_b_lane, l_b_lane};
    end
  end

  // Full carryless product, then reduction from the top bit down.
  function automatic logic [GF-1:0] gmul(input logic [GF-1:0] a, input logic [GF-1:0] b);
    logic [2*GF-2:0] prod;
    prod = '0;
    for (int i = 0; i < GF; i++)
      if (b[i]) prod = prod ^ ((2*GF-1)'(a) << i);
    for (int i = 2*GF-2; i >= GF; i--)
      if (prod[i]) prod = prod ^ ((2*GF-1)'({1'b1, POLY}) << (i - GF));
    return prod[GF-1:0];
  endfunction

  function automatic logic [2*W-1:0] exp_pair(input int r, input logic [W-1:0] w,
                                              input logic [GF-1:0] b);
    logic [W-1:0]  x0, x1;
    logic [GF-1:0] a;
    for (int l = 0; l < MW; l++) begin
      a = (l == 0) ? GF'(r + 1) : GF'(r + 5);
      x0[l*GF +: GF] = a ^ gmul(b, w[l*GF +: GF]);
      x1[l*GF +: GF] = x0[l*GF +: GF] ^ b;
    end
    return {x0, x1};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({rd_en, rd_addr, out_valid, out_e0, out_e1, busy, done} !== '0) begin
      miscompares++;
      $display("FAIL reset_small got %h want 0", {rd_en, rd_addr, out_valid, out_e0, out_e1, busy, done});
    end
    vectors++;
    if ({l_rd_en, l_rd_addr, l_out_valid, l_e0, l_e1, l_busy, l_done} !== '0) begin
      miscompares++;
      $display("FAIL reset_large got %h want 0", {l_rd_en, l_rd_addr, l_out_valid, l_e0, l_e1, l_busy, l_done});
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic(input logic [W-1:0] w, input logic [GF-1:0] b,
                            input logic [W-1:0] r0_e0, input logic [W-1:0] r0_e1,
                            input string name);
    int first_rd, ntr, ndone;
    logic [2*W-1:0] exp;
    first_rd = -1; ntr = 0; ndone = 0;
    sb.delete();
    for (int r = 0; r < ROWS; r++) sb.push_back(exp_pair(r, w, b));
    b_lane = b; twiddle = w; out_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      start = (k == 0); red_done = (k == 3);
      @(negedge clk);
      if (rd_en && first_rd < 0) first_rd = k;
      if (done) ndone++;
      if (out_valid && out_ready) begin
        if (ntr == 0) begin
          vectors++;
          if ({out_e0, out_e1} !== {r0_e0, r0_e1}) begin
            miscompares++;
            $display("FAIL %s_row0 got %h/%h want %h/%h", name, out_e0, out_e1, r0_e0, r0_e1);
          end
        end
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL %s_extra got %h/%h want none", name, out_e0, out_e1);
        end else begin
          exp = sb.pop_front();
          if ({out_e0, out_e1} !== exp) begin
            miscompares++;
            $display("FAIL %s_pair%0d got %h want %h", name, ntr, {out_e0, out_e1}, exp);
          end
        end
        ntr++;
      end
    end
    vectors++;
    if (first_rd !== 4) begin miscompares++; $display("FAIL %s_first_rd got %0d want 4", name, first_rd); end
    vectors++;
    if (ntr !== ROWS) begin miscompares++; $display("FAIL %s_count got %0d want %0d", name, ntr, ROWS); end
    vectors++;
    if (ndone !== 1) begin miscompares++; $display("FAIL %s_done got %0d want 1", name, ndone); end
  endtask

  task automatic test_stall();
    int ntr, ndone, stall_reads, unstable, have_ref;
    logic [2*W-1:0] exp, ref_pair;
    logic end_rd;
    ntr = 0; ndone = 0; stall_reads = 0; unstable = 0; have_ref = 0; end_rd = 1'b1;
    ref_pair = '0;
    sb.delete();
    for (int r = 0; r < ROWS; r++) sb.push_back(exp_pair(r, {13'd2, 13'd2}, 13'd3));
    b_lane = 13'd3; twiddle = {13'd2, 13'd2};
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      start = (k == 0); red_done = (k == 1);
      out_ready = !(k >= 1 && k <= 10);
      @(negedge clk);
      if (k >= 1 && k <= 10) begin
        if (rd_en) stall_reads++;
        if (k == 10) end_rd = rd_en;
        if (have_ref != 0 && ({out_e0, out_e1} !== ref_pair || !out_valid)) unstable++;
        if (out_valid && have_ref == 0) begin have_ref = 1; ref_pair = {out_e0, out_e1}; end
      end
      if (done) ndone++;
      if (out_valid && out_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL stall_extra got %h/%h want none", out_e0, out_e1);
        end else begin
          exp = sb.pop_front();
          if ({out_e0, out_e1} !== exp) begin
            miscompares++;
            $display("FAIL stall_pair%0d got %h want %h", ntr, {out_e0, out_e1}, exp);
          end
        end
        ntr++;
      end
    end
    vectors++;
    if (stall_reads > 2) begin miscompares++; $display("FAIL stall_reads got %0d want <=2", stall_reads); end
    vectors++;
    if (end_rd !== 1'b0) begin miscompares++; $display("FAIL stall_rd_en got %b want 0", end_rd); end
    vectors++;
    if (unstable != 0 || have_ref == 0) begin
      miscompares++;
      $display("FAIL stall_hold got %0d changes (ref seen %0d) want 0 changes", unstable, have_ref);
    end
    vectors++;
    if (ntr !== ROWS) begin miscompares++; $display("FAIL stall_count got %0d want %0d", ntr, ROWS); end
    vectors++;
    if (ndone !== 1) begin miscompares++; $display("FAIL stall_done got %0d want 1", ndone); end
  endtask

  task automatic test_same_cycle();
    int first_rd, ntr, ndone;
    logic busy_k1;
    logic [2*W-1:0] exp;
    first_rd = -1; ntr = 0; ndone = 0; busy_k1 = 1'b0;
    sb.delete();
    for (int r = 0; r < ROWS; r++) sb.push_back(exp_pair(r, {13'd2, 13'd2}, 13'd3));
    b_lane = 13'd3; out_ready = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      start    = (k == 0 || k == 2);
      red_done = (k == 0);
      twiddle  = (k == 0) ? {13'd2, 13'd2} : {13'h1000, 13'h1000};
      @(negedge clk);
      if (k == 1) busy_k1 = busy;
      if (rd_en && first_rd < 0) first_rd = k;
      if (done) ndone++;
      if (out_valid && out_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL same_extra got %h/%h want none", out_e0, out_e1);
        end else begin
          exp = sb.pop_front();
          if ({out_e0, out_e1} !== exp) begin
            miscompares++;
            $display("FAIL same_pair%0d got %h want %h", ntr, {out_e0, out_e1}, exp);
          end
        end
        ntr++;
      end
    end
    start = 1'b0;
    vectors++;
    if (first_rd !== 1) begin miscompares++; $display("FAIL same_first_rd got %0d want 1", first_rd); end
    vectors++;
    if (busy_k1 !== 1'b1) begin miscompares++; $display("FAIL same_busy got %b want 1", busy_k1); end
    vectors++;
    if (ntr !== ROWS) begin miscompares++; $display("FAIL same_count got %0d want %0d", ntr, ROWS); end
    vectors++;
    if (ndone !== 1) begin miscompares++; $display("FAIL same_done got %0d want 1", ndone); end
  endtask

  task automatic test_reset_mid();
    int ntr, ndone;
    logic [2*W-1:0] exp;
    ntr = 0; ndone = 0;
    sb.delete();
    for (int r = 0; r < ROWS; r++) sb.push_back(exp_pair(r, '0, 13'd3));
    b_lane = 13'd3; twiddle = '0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      start     = (k == 0 || k == 7);
      red_done  = (k == 0 || k == 7);
      rst       = (k == 5);
      out_ready = (k != 5);
      if (k == 5) begin
        vectors++;
        if (ntr !== 2) begin miscompares++; $display("FAIL rstmid_pre got %0d rows want 2", ntr); end
        ntr = 0;
        sb.delete();
        for (int r = 0; r < ROWS; r++) sb.push_back(exp_pair(r, '0, 13'd3));
      end
      @(negedge clk);
      if (k == 6) begin
        vectors++;
        if ({rd_en, rd_addr, out_valid, out_e0, out_e1, busy, done} !== '0) begin
          miscompares++;
          $display("FAIL rstmid_outputs got %h want 0", {rd_en, rd_addr, out_valid, out_e0, out_e1, busy, done});
        end
      end
      if (done) ndone++;
      if (out_valid && out_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL rstmid_extra got %h/%h want none", out_e0, out_e1);
        end else begin
          exp = sb.pop_front();
          if ({out_e0, out_e1} !== exp) begin
            miscompares++;
            $display("FAIL rstmid_pair%0d got %h want %h", ntr, {out_e0, out_e1}, exp);
          end
        end
        ntr++;
      end
    end
    vectors++;
    if (ntr !== ROWS) begin miscompares++; $display("FAIL rstmid_count got %0d want %0d", ntr, ROWS); end
    vectors++;
    if (ndone !== 1) begin miscompares++; $display("FAIL rstmid_done got %0d want 1", ndone); end
  endtask

  task automatic test_random();
    int ntr, ndone, tail, d;
    logic seen;
    logic [W-1:0] w;
    logic [GF-1:0] b;
    logic [2*W-1:0] exp;
    for (int run = 0; run < 256; run++) begin
      w = W'($urandom);
      b = GF'($urandom);
      d = int'($urandom_range(0, 3));
      sb.delete();
      for (int r = 0; r < ROWSL; r++) sb.push_back(exp_pair(r, w, b));
      l_twiddle = w; l_b_lane = b;
      ntr = 0; ndone = 0; tail = 0; seen = 1'b0;
      for (int k = 0; k < 700 && tail < 3; k++) begin
        @(posedge clk); #1;
        l_start = (k == 0); l_red_done = (k == d);
        l_out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (l_done) begin ndone++; seen = 1'b1; end
        if (seen) tail++;
        if (l_out_valid && l_out_ready) begin
          vectors++;
          if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL rand%0d_extra got %h/%h want none", run, l_e0, l_e1);
          end else begin
            exp = sb.pop_front();
            if ({l_e0, l_e1} !== exp) begin
              miscompares++;
              $display("FAIL rand%0d_pair%0d got %h want %h", run, ntr, {l_e0, l_e1}, exp);
            end
          end
          ntr++;
        end
      end
      vectors++;
      if (ntr !== ROWSL) begin miscompares++; $display("FAIL rand%0d_count got %0d want %0d", run, ntr, ROWSL); end
      vectors++;
      if (ndone !== 1) begin miscompares++; $display("FAIL rand%0d_done got %0d want 1 (timeout if 0)", run, ndone); end
    end
    l_start = 1'b0; l_red_done = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic('0, 13'd3, {13'd5, 13'd1}, {13'd6, 13'd2}, "w0");
    test_basic({13'd2, 13'd2}, 13'd3, {13'd3, 13'd7}, {13'd0, 13'd4}, "w2");
    test_basic({13'h1000, 13'h1000}, 13'd2, {13'h001E, 13'h001A}, {13'h001C, 13'h0018}, "w1000");
    test_stall();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
